// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types, constants and op decode helpers for the RV32M muldiv unit
//
// Purpose: funct3 op encoding, FSM state encoding, width/step constants and
// small decode helpers used by muldiv_unit and div_iter.
// Ports: none (package).

package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int DIV_STEPS    = 32;
  localparam int CNT_W        = 6;

  // RISC-V funct3 encodings for the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  // MUL treats a as signed; its low half does not depend on signedness anyway
  function automatic logic is_signed_a(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// rtl/muldiv_div_iter.sv - radix-2 restoring divider datapath on unsigned magnitudes
//
// Purpose: produces one quotient bit per step over DIV_STEPS steps.
// Ports:
//   clk_i       clock
//   reset_i     synchronous active-high reset
//   load_i      latch dividend/divisor magnitudes and clear the step counter
//   step_i      perform one restoring iteration
//   dividend_i  unsigned dividend magnitude
//   divisor_i   unsigned divisor magnitude
//   quot_o      quotient (valid after the last step)
//   rem_o       remainder (valid after the last step)
//   last_o      high while the step counter points at the final iteration

module div_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            last_o
);

  logic [XLEN-1:0]  divisor_q;
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  quot_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            fits;

  // quot_q starts out holding the dividend; its MSB is shifted into the
  // partial remainder while the new quotient bit enters at the LSB.
  assign shifted = {rem_q, quot_q[XLEN-1]};
  assign diff    = shifted - {2'b00, divisor_q};
  assign fits    = ~diff[XLEN+1];  // no borrow: subtract succeeds

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
    end else if (load_i) begin
      divisor_q <= divisor_i;
      rem_q     <= '0;
      quot_q    <= dividend_i;
      cnt_q     <= '0;
    end else if (step_i) begin
      rem_q  <= fits ? diff[XLEN:0] : shifted[XLEN:0];
      quot_q <= {quot_q[XLEN-2:0], fits};
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q[XLEN-1:0];
  assign last_o = (cnt_q == CNT_W'(DIV_STEPS - 1));

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M multiply/divide execute unit
//
// Purpose: 2-cycle multiply, 34-cycle restoring divide/remainder, 1-cycle
// resolution of divide-by-zero and signed overflow.
// Ports:
//   clk     clock
//   reset   synchronous active-high reset
//   start   request pulse, sampled only when idle
//   flush   abort any in-flight op (no done, result unchanged)
//   op      funct3 op code
//   a, b    rs1 / rs2 operands
//   busy    unit is not idle
//   done    one-cycle pulse, result valid
//   result  registered result, held until the next completion

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  if (XLEN != 32) begin : g_xlen_check
    $error("muldiv_unit supports only XLEN=32");
  end

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  op_e             op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] result_q;
  logic            busy_q;
  logic            done_q;

  op_e op_in;
  assign op_in = op_e'(op);

  // ---------------- special cases, decided from the raw inputs ----------------
  logic            div_by_zero;
  logic            div_overflow;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign div_by_zero  = (b == '0);
  assign div_overflow = is_signed_a(op_in) && (a == INT_MIN) && (b == '1);
  assign special      = div_by_zero || div_overflow;
  // op[1] selects the remainder flavour
  assign special_res  = op_in[1] ? (div_by_zero ? a  : '0)
                                 : (div_by_zero ? '1 : INT_MIN);

  // ---------------- multiply: 33x33 signed product, low 64 bits ----------------
  logic [XLEN:0]     mul_a_ext;
  logic [XLEN:0]     mul_b_ext;
  logic [2*XLEN-1:0] prod;

  assign mul_a_ext = {is_signed_a(op_q) & a_q[XLEN-1], a_q};
  assign mul_b_ext = {is_signed_b(op_q) & b_q[XLEN-1], b_q};
  // Operands are sign-extended to the full product width so an unsigned
  // multiply yields the two's-complement signed product.
  assign prod = {{(XLEN-1){mul_a_ext[XLEN]}}, mul_a_ext} *
                {{(XLEN-1){mul_b_ext[XLEN]}}, mul_b_ext};

  // ---------------- divider ----------------
  logic            div_load;
  logic            div_step;
  logic            div_last;
  logic [XLEN-1:0] dividend_mag;
  logic [XLEN-1:0] divisor_mag;
  logic [XLEN-1:0] div_quot;
  logic [XLEN-1:0] div_rem;

  assign dividend_mag = (is_signed_a(op_in) && a[XLEN-1]) ? -a : a;
  assign divisor_mag  = (is_signed_b(op_in) && b[XLEN-1]) ? -b : b;
  assign div_load     = (state_q == ST_IDLE) && start && !flush && is_div(op_in);
  assign div_step     = (state_q == ST_DIV);

  div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (dividend_mag),
    .divisor_i  (divisor_mag),
    .quot_o     (div_quot),
    .rem_o      (div_rem),
    .last_o     (div_last)
  );

  // ---------------- sign fix-up ----------------
  logic            neg_quot;
  logic            neg_rem;
  logic [XLEN-1:0] fix_res;

  assign neg_quot = (op_q == OP_DIV) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign neg_rem  = (op_q == OP_REM) && a_q[XLEN-1];
  assign fix_res  = op_q[1] ? (neg_rem  ? -div_rem  : div_rem)
                            : (neg_quot ? -div_quot : div_quot);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op_in;
            a_q    <= a;
            b_q    <= b;
            busy_q <= 1'b1;
            if (!is_div(op_in)) begin
              state_q <= ST_MUL;
            end else if (special) begin
              result_q <= special_res;
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
            end else begin
              state_q <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          result_q <= (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_q  <= ST_DONE;
          done_q   <= 1'b1;
        end
        ST_DIV: begin
          if (div_last) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_q <= fix_res;
          state_q  <= ST_DONE;
          done_q   <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit

module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_mis = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RV32M golden model in plain arithmetic
  function automatic logic [31:0] golden(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int          sx;
    int          sy;
    longint      p;
    logic [63:0] w;
    sx = x;
    sy = y;
    case (o)
      3'd0: begin w = {32'd0, x} * {32'd0, y}; return w[31:0]; end
      3'd1: begin p = longint'(sx) * longint'(sy); w = p; return w[63:32]; end
      3'd2: begin p = longint'(sx) * longint'({32'd0, y}); w = p; return w[63:32]; end
      3'd3: begin w = {32'd0, x} * {32'd0, y}; return w[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return sx / sy;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int golden_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[2]) return 2;
    if (y == 0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called at a negedge in an idle cycle; returns at the negedge of the done cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat, output bit busy_ok);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    res = result;
  endtask

  task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int          lat;
    bit          bok;
    do_op(o, x, y, res, lat, bok);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, {31'd0, bok}, 32'd1);
    @(negedge clk);
  endtask

  logic [31:0] edge_vals [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return edge_vals[$urandom_range(0, 4)];
      1:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  ro;
    int          lat;
    int          n_done;
    bit          bok;

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);

    // multiply
    run_check("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run_check("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_check("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_check("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    // divide / remainder
    run_check("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_check("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_check("divu", 3'b101, 32'd100,       32'd7, 32'd14,        34);
    run_check("remu", 3'b111, 32'd100,       32'd7, 32'd2,         34);

    // special cases
    run_check("divu_z", 3'b101, 32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run_check("rem_z",  3'b110, 32'd100,       32'd0,         32'd100,       1);
    run_check("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_check("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // start held high through DONE is ignored there; next op needs the idle cycle
    op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    check("hold_res", result, 32'd14);
    check("hold_lat", 32'(lat), 32'd34);
    op = 3'b000; a = 32'd3; b = 32'd5;
    @(negedge clk);
    check("hold_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("hold_accept_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("hold_mul_done", {31'd0, done}, 32'd1);
    check("hold_mul_res", result, 32'd15);
    @(negedge clk);

    // flush at k+10 of a divide
    op = 3'b100; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    repeat (9) begin if (done) n_done++; @(negedge clk); end
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_nodone_cnt", 32'(n_done), 32'd0);
    check("flush_result_kept", result, 32'd15);
    run_check("post_flush_remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);

    // reset at k+20 of a divide
    op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    n_done = 0;
    repeat (40) begin @(negedge clk); if (done) n_done++; end
    check("rst_mid_no_stale_done", 32'(n_done), 32'd0);

    // start and flush together in IDLE
    op = 3'b000; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", {31'd0, busy}, 32'd0);
    n_done = 0;
    repeat (4) begin @(negedge clk); if (done || busy) n_done++; end
    check("start_flush_quiet", 32'(n_done), 32'd0);
    check("start_flush_result", result, 32'd0);

    // randomized
    for (int i = 0; i < 2000; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      do_op(ro, ra, rb, res, lat, bok);
      check("rand_res", res, golden(ro, ra, rb));
      check("rand_lat", 32'(lat), 32'(golden_lat(ro, ra, rb)));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
